// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and the fetch-queue entry type for the CPU front end.
package cpu_pkg;
   localparam int          INSTR_MEM_SIZE = 128;
   localparam int          WORD_BYTES     = 4;
   localparam logic [31:0] RESET_PC       = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetch entries with flush.
// Ports: clk, rst_n (async active-low); push/din write an entry, pop retires the
// head, flush empties the queue; head is the oldest entry (zero when empty),
// count is the occupancy and valid flags a non-empty queue.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t din,
   output fetch_entry_t head,
   output logic [CW-1:0] count,
   output logic         valid
);
   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;

   assign valid = count != '0;
   // Head reads as zero when empty so stale entries never leak after a flush.
   assign head  = valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk)
      if (push && !flush) mem[wr_ptr] <= din;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC register, instruction fetch into a prefetch queue, redirect and fault handling.
// Ports: clk, rst_n (async active-low); Instr_Addr/Instruction form the combinational
// instruction-memory read; redirect_valid/redirect_pc steer the PC and flush the queue;
// out_valid/out_ready/out_instr/out_pc hand entries to decode; fault is the sticky fetch fault.
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int          INSTR_MEM_SIZE = cpu_pkg::INSTR_MEM_SIZE,
   parameter int          QDEPTH         = 4,
   parameter logic [31:0] RESET_PC       = cpu_pkg::RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] Instr_Addr,
   input  logic [31:0] Instruction,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        fault
);
   localparam int          CW      = $clog2(QDEPTH) + 1;
   localparam logic [31:0] LAST_PC = 32'(INSTR_MEM_SIZE - WORD_BYTES);

   logic [31:0]   pc;
   logic [CW-1:0] count;
   logic          pop, fetch_en, push, bad_target;
   fetch_entry_t  head;

   assign Instr_Addr = pc;
   assign pop        = out_valid && out_ready;
   assign fetch_en   = !fault && !redirect_valid && (count < CW'(QDEPTH) || pop);
   // The range check also catches pc+4 wrapping past 2^32.
   assign push       = fetch_en && pc <= LAST_PC;
   assign bad_target = |redirect_pc[1:0] || redirect_pc > LAST_PC;
   assign out_instr  = head.instr;
   assign out_pc     = head.pc;

   fetch_queue #(.DEPTH(QDEPTH)) u_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .din   ('{pc: pc, instr: Instruction}),
      .head  (head),
      .count (count),
      .valid (out_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc    <= RESET_PC;
         fault <= 1'b0;
      end else begin
         pc    <= redirect_valid ? redirect_pc : push ? pc + 32'd4 : pc;
         fault <= redirect_valid ? bad_target : (fetch_en && !push) ? 1'b1 : fault;
      end
   end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench for instr_fetch_unit with directed vectors.
module tb_instr_fetch_unit;
   logic        clk = 0;
   logic        rst_n;
   logic [31:0] Instr_Addr, Instruction, redirect_pc, out_instr, out_pc;
   logic        redirect_valid, out_valid, out_ready, fault;
   int          checks = 0, fails = 0;
   logic [31:0] exp_q[$];

   instr_fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .Instr_Addr(Instr_Addr), .Instruction(Instruction),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
      .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .fault(fault)
   );

   always #5 clk = ~clk;

   // Memory image: word at byte address a holds 0x20080001 + a/4.
   assign Instruction = 32'h2008_0001 + (Instr_Addr >> 2);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted head must be the next expected pc with its memory word.
   initial forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) chk("unexpected_delivery", out_pc, 32'hFFFF_FFFF);
         else begin
            logic [31:0] p;
            p = exp_q.pop_front();
            chk("sb_pc", out_pc, p);
            chk("sb_instr", out_instr, 32'h2008_0001 + (p >> 2));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 0; out_ready = 1; redirect_valid = 0; redirect_pc = 0;
      repeat (3) tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_pc", out_pc, 0);
      chk("rst_instr", out_instr, 0);
      chk("rst_fault", fault, 0);
      chk("rst_addr", Instr_Addr, 0);
      for (int k = 0; k < 13; k++) exp_q.push_back(32'(4 * k));
      rst_n = 1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk("addr_step", Instr_Addr, 32'(4 * k));
         chk("stream_valid", out_valid, 1);
         if (k == 1) begin
            chk("first_pc", out_pc, 0);
            chk("first_instr", out_instr, 32'h2008_0001);
         end
      end
      out_ready = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("stall_head", out_pc, 32'h1C);
      end
      chk("full_addr_hold", Instr_Addr, 32'h2C);
      out_ready = 1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("drain_valid", out_valid, 1);
         chk("drain_addr", Instr_Addr, 32'(32'h30 + 4 * k));
      end
      out_ready = 0; redirect_valid = 1; redirect_pc = 32'h50;
      tick();
      redirect_valid = 0;
      chk("redir1_valid", out_valid, 0);
      chk("redir1_addr", Instr_Addr, 32'h50);
      repeat (3) tick();
      chk("three_q_head", out_pc, 32'h50);
      chk("three_q_addr", Instr_Addr, 32'h5C);
      for (int k = 0; k < 16; k++) exp_q.push_back(32'(32'h40 + 4 * k));
      redirect_valid = 1; redirect_pc = 32'h40;
      tick();
      redirect_valid = 0; out_ready = 1;
      chk("flush_valid", out_valid, 0);
      chk("flush_addr", Instr_Addr, 32'h40);
      tick();
      chk("target_pc", out_pc, 32'h40);
      chk("target_valid", out_valid, 1);
      repeat (15) tick();
      chk("last_head", out_pc, 32'h7C);
      chk("last_addr", Instr_Addr, 32'h80);
      chk("last_nofault", fault, 0);
      tick();
      chk("range_fault", fault, 1);
      chk("range_valid", out_valid, 0);
      chk("range_addr", Instr_Addr, 32'h80);
      repeat (3) tick();
      chk("range_hold_addr", Instr_Addr, 32'h80);
      chk("range_hold_valid", out_valid, 0);
      redirect_valid = 1; redirect_pc = 32'h06;
      tick();
      redirect_valid = 0;
      chk("mis_fault", fault, 1);
      chk("mis_addr", Instr_Addr, 32'h06);
      repeat (2) tick();
      chk("mis_nofetch_valid", out_valid, 0);
      chk("mis_nofetch_addr", Instr_Addr, 32'h06);
      redirect_valid = 1; redirect_pc = 32'h10;
      tick();
      redirect_valid = 0; out_ready = 0;
      chk("clear_fault", fault, 0);
      chk("clear_addr", Instr_Addr, 32'h10);
      chk("clear_valid", out_valid, 0);
      tick();
      chk("clear_target_pc", out_pc, 32'h10);
      chk("clear_target_valid", out_valid, 1);
      repeat (2) tick();
      chk("pre_rst_addr", Instr_Addr, 32'h1C);
      #2 rst_n = 0;
      #1;
      chk("async_valid", out_valid, 0);
      chk("async_fault", fault, 0);
      chk("async_addr", Instr_Addr, 0);
      chk("async_pc", out_pc, 0);
      tick();
      rst_n = 1;
      tick();
      chk("post_rst_pc", out_pc, 0);
      chk("post_rst_valid", out_valid, 1);
      chk("sb_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface: holds the PC, drives the byte address to the combinational big-endian instruction memory, and captures the returned 32-bit word.
- Buffers fetched words with their PCs in a small prefetch queue and presents them to decode over a valid/ready handshake.
- Supports branch/jump redirect with queue flush, and raises a sticky fault on misaligned or out-of-range PCs.
- Sits between the instruction memory and the decode stage of the single-clock CPU.

Parameters:
- INSTR_MEM_SIZE, 128, instruction memory size in bytes; the last legal fetch PC is INSTR_MEM_SIZE-4.
- QDEPTH, 4, prefetch queue depth in entries; must be a power of two and at least 2.
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- Instr_Addr, output, 32, byte address to the instruction memory; combinationally equal to the PC register.
- Instruction, input, 32, word returned by the instruction memory in the same cycle (combinational read).
- redirect_valid, input, 1, a branch/jump target is presented this cycle.
- redirect_pc, input, 32, target PC for the redirect.
- out_valid, output, 1, the queue head is valid.
- out_ready, input, 1, decode accepts the queue head this cycle.
- out_instr, output, 32, instruction word at the queue head.
- out_pc, output, 32, PC of the queue-head instruction.
- fault, output, 1, sticky fetch fault.

Behaviour:
- Reset (asynchronous, while rst_n=0): pc=RESET_PC; queue empty (rd_ptr=wr_ptr=0, count=0); out_valid=0; out_instr=0; out_pc=0; fault=0; Instr_Addr=RESET_PC.
- Fetch:
  - fetch_en = !fault && !redirect_valid && (count<QDEPTH || pop).
  - pop = out_valid && out_ready.
  - When fetch_en: at the edge, push {pc, Instruction} and set pc <= pc+4.
  - Latency: an instruction is visible at the head one cycle after its address is driven.
- Range check: if pc > INSTR_MEM_SIZE-4 while fetch_en would otherwise be 1, nothing is pushed, fault <= 1, and pc holds.
- Output:
  - out_valid = (count != 0).
  - out_instr and out_pc come from the head entry.
  - pop advances rd_ptr.
  - Head data is stable while out_valid=1 && out_ready=0.
- Simultaneous push and pop: count is unchanged; this is allowed when full and gives sustained 1 instruction per cycle.
- Pointers: wrap modulo QDEPTH; count has width clog2(QDEPTH)+1.
- Redirect (highest priority):
  - At the edge, the queue is flushed (count=0, pointers=0) and pc <= redirect_pc.
  - No push occurs in that cycle.
  - A pop in the same cycle still counts as consumed by decode.
  - out_valid=0 in the following cycle; the first target instruction is valid two cycles after redirect_valid.
  - If redirect_pc[1:0] != 0 or redirect_pc > INSTR_MEM_SIZE-4: fault <= 1 and pc <= redirect_pc (fetch stays stopped).
  - Otherwise fault <= 0, which is the only way to clear fault other than reset.
- While fault=1: already-queued entries continue to drain normally; no new fetches.
- Reset mid-operation: all state returns to reset values immediately; in-flight entries are discarded.
- Arithmetic: 32-bit PC; pc+4 wraps modulo 2^32, and the range check catches any such wrap.

Decomposition:
- Shared package (cpu_pkg): INSTR_MEM_SIZE, WORD_BYTES=4, RESET_PC, and a fetch-entry typedef {pc[31:0], instr[31:0]}.
- One natural sub-module: fetch_queue, a parameterised synchronous FIFO with push/pop/flush, count, and head data.
- The top level holds the PC register, fetch_en logic, range/alignment checks, and the fault flag.

Test Plan:
1. Reset then release, out_ready=1, memory words 0x00000000..0x0000001C hold 0x20080001+k → Instr_Addr steps 0,4,8,... one per cycle; out_valid first asserts one cycle after release with out_pc=0, out_instr=0x20080001; one instruction per cycle thereafter.
2. out_ready=0 for 10 cycles → exactly 4 entries are queued and Instr_Addr holds at 0x10. Then raise out_ready → entries at pc 0,4,8,0xC drain in order with no gap and fetch resumes.
3. Redirect with redirect_pc=0x40 while the queue holds 3 entries → the next cycle has out_valid=0 and Instr_Addr=0x40; the following cycle has out_pc=0x40. No stale entry ever appears.
4. Run sequentially to pc=0x7C → the entry at 0x7C is delivered; at pc=0x80 fault=1, nothing is pushed, and Instr_Addr holds at 0x80.
5. Redirect with redirect_pc=0x06 → fault=1 and no fetch occurs. Then redirect with redirect_pc=0x10 → fault=0 and out_pc=0x10 two cycles later.
6. Assert rst_n=0 asynchronously mid-stream with 3 entries queued → out_valid=0 and fault=0 immediately, and Instr_Addr=RESET_PC without waiting for a clock edge.
